// File: rtl/band_mix_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | band_mix_pkg : shared FSM encoding and accumulator width helper  |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package band_mix_pkg;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_ACCUM = 2'd1;
  localparam logic [1:0] C_ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_ACCUM = C_ST_ACCUM,
    ST_DONE  = C_ST_DONE
  } state_e;

  // Wide enough that summing every band at full scale can never wrap.
  function automatic int acc_width(input int data_w, input int num_bands);
    return data_w + $clog2(num_bands) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clamp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_clamp : signed saturating narrow from IN_W to OUT_W bits     |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module sat_clamp #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             sat_o
);

  localparam int C_HEAD_W = IN_W - OUT_W + 1;

  logic [C_HEAD_W-1:0] w_head;
  logic                w_fits;

  // Value fits when every bit above the output sign bit matches it.
  assign w_head = din_i[IN_W-1:OUT_W-1];
  assign w_fits = (w_head == '0) || (w_head == '1);

  always_comb begin
    dout_o = din_i[OUT_W-1:0];
    sat_o  = 1'b0;
    if (!w_fits) begin
      sat_o  = 1'b1;
      dout_o = din_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                             : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/band_mix_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | band_mix_seq : sequential one-band-per-cycle saturating mixer    |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module band_mix_seq
  import band_mix_pkg::*;
#(
  parameter int NUM_BANDS = 5,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BANDS*DATA_W-1:0] bands_in,
  input  logic [NUM_BANDS-1:0]        band_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sat_flag,
  input  logic                        sat_clr
);

  localparam int ACC_W = acc_width(DATA_W, NUM_BANDS);
  localparam int IDX_W = $clog2(NUM_BANDS + 1);
  // Index value meaning "every band has been added".
  localparam logic [IDX_W-1:0] C_IDX_END = IDX_W'(NUM_BANDS);

  state_e                      state_q, state_d;
  logic [NUM_BANDS*DATA_W-1:0] bands_q, bands_d;
  logic [NUM_BANDS-1:0]        en_q, en_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DATA_W-1:0]           out_q, out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        sat_q, sat_d;

  logic [ACC_W-1:0]            w_addend;
  logic [DATA_W-1:0]           w_clamped;
  logic                        w_sat;

  always_comb begin
    w_addend = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      if ((idx_q == IDX_W'(k)) && en_q[k]) begin
        w_addend = {{(ACC_W-DATA_W){bands_q[k*DATA_W+DATA_W-1]}},
                    bands_q[k*DATA_W +: DATA_W]};
      end
    end
  end

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_clamp (
    .din_i  (acc_q),
    .dout_o (w_clamped),
    .sat_o  (w_sat)
  );

  always_comb begin
    state_d     = state_q;
    bands_d     = bands_q;
    en_d        = en_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q & ~sat_clr;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bands_d = bands_in;
          en_d    = band_en;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (idx_q == C_IDX_END) begin
          out_d       = w_clamped;
          out_valid_d = 1'b1;
          sat_d       = sat_d | w_sat;
          state_d     = ST_DONE;
        end else begin
          acc_d = acc_q + w_addend;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bands_q     <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bands_q     <= bands_d;
      en_q        <= en_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_band_mix_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_band_mix_seq : scoreboard bench for band_mix_seq (5x16, 8x12) |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module tb_band_mix_seq;

  localparam int NB  = 5;
  localparam int DW  = 16;
  localparam int NB2 = 8;
  localparam int DW2 = 12;

  typedef struct {
    longint val;
    bit     sat;
    int     acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB*DW-1:0]   bands_in  = '0;
  logic [NB-1:0]      band_en   = '0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic [DW-1:0]      a_out;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               sat_flag;
  logic               sat_clr   = 1'b0;

  logic [NB2*DW2-1:0] b_bands     = '0;
  logic [NB2-1:0]     b_en        = '0;
  logic               b_in_valid  = 1'b0;
  logic               b_in_ready;
  logic [DW2-1:0]     b_out;
  logic               b_out_valid;
  logic               b_out_ready = 1'b1;
  logic               b_sat;
  logic               b_sat_clr   = 1'b0;

  band_mix_seq #(.NUM_BANDS(NB), .DATA_W(DW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bands_in(bands_in), .band_en(band_en),
    .in_valid(in_valid), .in_ready(in_ready), .out(a_out), .out_valid(out_valid),
    .out_ready(out_ready), .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  band_mix_seq #(.NUM_BANDS(NB2), .DATA_W(DW2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bands_in(b_bands), .band_en(b_en),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out(b_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sat_flag(b_sat), .sat_clr(b_sat_clr)
  );

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   cyc        = 0;
  int   valid_seen = 0;
  bit   model_sat  = 1'b0;
  bit   b_model_sat = 1'b0;
  bit   rand_done  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: integer sum of enabled bands, then clamp to the signed range.
  function automatic exp_t model(input logic [255:0] b, input logic [15:0] e,
                                 input int nb, input int dw);
    exp_t   r;
    longint sum = 0;
    longint v;
    longint hi = (longint'(1) << (dw - 1)) - 1;
    longint lo = -(longint'(1) << (dw - 1));
    for (int k = 0; k < nb; k++) begin
      if (e[k]) begin
        v = 0;
        for (int j = 0; j < dw; j++)
          if (b[k*dw+j]) v += (j == dw - 1) ? -(longint'(1) << j) : (longint'(1) << j);
        sum += v;
      end
    end
    r.sat = (sum > hi) || (sum < lo);
    if (sum > hi) sum = hi;
    else if (sum < lo) sum = lo;
    r.val = sum & ((longint'(1) << dw) - 1);
    r.acc = 0;
    return r;
  endfunction

  function automatic logic [NB*DW-1:0] pack_a(input int v0, v1, v2, v3, v4);
    return {DW'(v4), DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
  endfunction

  function automatic logic [NB2*DW2-1:0] pack_b(input int v0, v1, v2, v3, v4, v5, v6, v7);
    return {DW2'(v7), DW2'(v6), DW2'(v5), DW2'(v4), DW2'(v3), DW2'(v2), DW2'(v1), DW2'(v0)};
  endfunction

  function automatic logic [NB*DW-1:0] rand_a();
    logic [NB*DW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Offer one sample set to A; expected result is queued at the accept point.
  task automatic send_a(input logic [NB*DW-1:0] b, input logic [NB-1:0] e);
    exp_t x;
    int   n = 0;
    bands_in = b;
    band_en  = e;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept wait", longint'(in_ready), 1);
    if (in_ready) begin
      x     = model(256'(b), 16'(e), NB, DW);
      x.acc = cyc + 1;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bands_in = rand_a();
    band_en  = NB'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain pending", exp_q.size(), 0);
  endtask

  task automatic run_b(input logic [NB2*DW2-1:0] b, input logic [NB2-1:0] e);
    exp_t x;
    int   n = 0;
    int   a;
    b_bands    = b;
    b_en       = e;
    b_in_valid = 1'b1;
    while (!b_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("B accept wait", longint'(b_in_ready), 1);
    x = model(256'(b), 16'(e), NB2, DW2);
    a = cyc + 1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_bands    = ~b;
    n = 0;
    while (!b_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("B latency", cyc - a, NB2 + 1);
    chk("B out", longint'(b_out), x.val);
    b_model_sat |= x.sat;
    chk("B sat_flag", longint'(b_sat), longint'(b_model_sat));
  endtask

  // Monitor: each new result is checked against the head of the queue.
  initial begin
    bit prev_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          valid_seen++;
          if (exp_q.size() == 0) begin
            chk("spurious out_valid (queue size)", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc - e.acc, NB + 1);
            chk("out", longint'(a_out), e.val);
            model_sat |= e.sat;
            chk("sat_flag on load", longint'(sat_flag), longint'(model_sat));
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    logic [DW-1:0] held;
    int n;
    int snap;

    @(negedge clk);
    chk("reset in_ready", longint'(in_ready), 1);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset out", longint'(a_out), 0);
    chk("reset sat_flag", longint'(sat_flag), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Accept on the very first edge after release.
    send_a(pack_a(100, 200, -50, 25, 5), 5'h1f);
    drain();
    chk("basic sum", longint'(a_out), 280);
    chk("basic sat", longint'(sat_flag), 0);

    send_a(pack_a('h7000, 'h7000, 'h7000, 'h7000, 'h7000), 5'h1f);
    drain();
    chk("pos clamp", longint'(a_out), 'h7FFF);
    #1 sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    model_sat = 1'b0;
    chk("sat cleared", longint'(sat_flag), 0);

    // Clear coincides with the clamped load edge: set must win.
    send_a(pack_a('h9000, 'h9000, 'h9000, 'h9000, 'h9000), 5'h1f);
    repeat (NB) @(posedge clk);
    #1 sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    chk("set beats clear", longint'(sat_flag), 1);
    chk("neg clamp", longint'(a_out), 'h8000);
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    model_sat = 1'b0;
    chk("sat cleared 2", longint'(sat_flag), 0);
    drain();

    send_a(pack_a(1000, 1000, 1000, 1000, 1000), 5'b00101);
    drain();
    chk("partial enable", longint'(a_out), 2000);
    send_a(pack_a(1000, -7, 1234, 99, -300), 5'b00000);
    drain();
    chk("all muted", longint'(a_out), 0);

    // Backpressure in DONE.
    out_ready = 1'b0;
    send_a(pack_a(-1, 2, -3, 4, -5), 5'h1f);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold valid", longint'(out_valid), 1);
    held     = a_out;
    bands_in = rand_a();
    band_en  = '1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold out", longint'(a_out), longint'(held));
      chk("hold in_ready", longint'(in_ready), 0);
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release valid", longint'(out_valid), 0);
    chk("release in_ready", longint'(in_ready), 1);
    chk("out retained", longint'(a_out), longint'(held));
    drain();

    fork
      begin
        for (int t = 0; t < 40; t++) begin
          send_a(rand_a(), NB'($urandom));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset while band index is 2.
    send_a(pack_a(11, 22, 33, 44, 55), 5'h1f);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_sat = 1'b0;
    chk("abort in_ready", longint'(in_ready), 1);
    chk("abort out_valid", longint'(out_valid), 0);
    chk("abort out", longint'(a_out), 0);
    chk("abort sat_flag", longint'(sat_flag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap  = valid_seen;
    repeat (NB + 6) @(negedge clk);
    chk("no result after abort", valid_seen - snap, 0);
    chk("idle after abort", longint'(in_ready), 1);

    run_b(pack_b(100, 200, -50, 25, 5, 10, -20, 30), 8'hff);
    chk("B basic sum", longint'(b_out), 300);
    run_b(pack_b('h700, 'h700, 'h700, 'h700, 'h700, 'h700, 'h700, 'h700), 8'hff);
    chk("B pos clamp", longint'(b_out), 'h7FF);
    #1 b_sat_clr = 1'b1;
    @(posedge clk);
    #1 b_sat_clr = 1'b0;
    chk("B sat cleared", longint'(b_sat), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
